dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitrates the single-port data memory between the pipeline's execute-stage load/store path (core) and a DMA/debug requester. Grants one access per cycle and routes read data back to the requester that issued it. Asserts a stall to the hazard logic whenever the core requests but is not granted. Sits between the LSU sizing logic and the data memory.

Parameters:
AW, 32, address width
DW, 32, data width; mask width is DW/8
STARVE_LIMIT, 3, consecutive core grants allowed while DMA waits before DMA is forced in (>=1)
DMA_MAX_HOLD, 4, max consecutive DMA beats while core waits (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
core_req  in  1  core access request (level, held until granted)
core_wr  in  1  1=store, 0=load
core_addr  in  AW  core address
core_wdata  in  DW  core store data
core_mask  in  DW/8  core byte enables
core_stall  out  1  core_req & ~core granted this cycle
core_rdata  out  DW  load data, valid when core_rvalid
core_rvalid  out  1  core load data valid
dma_req  in  1  DMA request (level)
dma_wr  in  1  1=write, 0=read
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_mask  in  DW/8  DMA byte enables
dma_gnt  out  1  DMA access accepted this cycle
dma_rdata  out  DW  read data, valid when dma_rvalid
dma_rvalid  out  1  DMA read data valid
mem_cs  out  1  memory chip select
mem_wr  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_mask  out  DW/8  memory byte enables
mem_rdata  in  DW  memory read data, one cycle after read access

Behaviour:
- Registered state: owner {CORE_OWN, DMA_OWN}, starve_cnt, burst_cnt, rtag {NONE, CORE, DMA}.
- Grant is combinational from registered state + current requests; mem_* mux the granted requester's signals; mem_cs = any grant; with no grant mem_cs=mem_wr=0, other mem_* = 0.
- CORE_OWN: core_req only -> core. dma_req only -> DMA, go DMA_OWN, burst_cnt=1. Both: if starve_cnt==STARVE_LIMIT -> DMA, go DMA_OWN, burst_cnt=1, starve_cnt=0; else core, starve_cnt+1. starve_cnt cleared whenever dma_req=0.
- DMA_OWN: dma_req & burst_cnt<DMA_MAX_HOLD -> DMA, burst_cnt+1. dma_req & burst_cnt==DMA_MAX_HOLD & core_req -> core, go CORE_OWN, starve_cnt=1. dma_req & burst_cnt==DMA_MAX_HOLD & ~core_req -> DMA, burst_cnt saturates. ~dma_req -> core if core_req; go CORE_OWN, burst_cnt=0, starve_cnt=0.
- Neither request: no grant, state unchanged except counters per rules above.
- Read latency 1: granted read sets rtag next cycle; core_rvalid=(rtag==CORE), dma_rvalid=(rtag==DMA); rdata = mem_rdata when corresponding rvalid, else 0. Writes leave rtag=NONE. Back-to-back reads from alternating requesters fully pipelined.
- core_stall and dma_gnt combinational, same cycle as request.
- Reset: owner=CORE_OWN, counters 0, rtag=NONE; while reset high all grants forced 0, mem_cs=0, core_stall=0, rvalids 0. Reset mid-burst aborts burst; in-flight read data dropped (no rvalid after reset).

Test Plan:
- Core-only load addr 0x40, mem returns 0xDEADBEEF -> same cycle mem_cs=1 mem_wr=0 mem_addr=0x40 core_stall=0; next cycle core_rvalid=1 core_rdata=0xDEADBEEF.
- DMA-only 6 writes, core idle, DMA_MAX_HOLD=4 -> dma_gnt high 6 consecutive cycles, mem_wr=1 each, no gaps.
- Both requesting continuously (STARVE_LIMIT=3, DMA_MAX_HOLD=4) -> grant pattern C C C D D D D C C C D D D D; core_stall=1 exactly in D cycles.
- Alternating reads core 0x10 then DMA 0x20 -> core_rvalid cycle t+1, dma_rvalid cycle t+2, each with its own mem_rdata, never both high.
- In DMA_OWN burst_cnt=2, dma_req drops while core_req high -> core granted same cycle, core_stall=0, owner=CORE_OWN next.
- Reset asserted during 2nd DMA read beat -> next cycle dma_rvalid=0, owner=CORE_OWN; core_req after reset release granted immediately.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core LSU and a DMA/debug port.
// One access per cycle; read data is steered back by a one-deep tag.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 3,
  parameter int DMA_MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            core_req,
  input  logic            core_wr,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW-1:0]   core_wdata,
  input  logic [DW/8-1:0] core_mask,
  output logic            core_stall,
  output logic [DW-1:0]   core_rdata,
  output logic            core_rvalid,
  input  logic            dma_req,
  input  logic            dma_wr,
  input  logic [AW-1:0]   dma_addr,
  input  logic [DW-1:0]   dma_wdata,
  input  logic [DW/8-1:0] dma_mask,
  output logic            dma_gnt,
  output logic [DW-1:0]   dma_rdata,
  output logic            dma_rvalid,
  output logic            mem_cs,
  output logic            mem_wr,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_mask,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(DMA_MAX_HOLD + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BMAX = BW'(DMA_MAX_HOLD);

  typedef enum logic {
    CORE_OWN,
    DMA_OWN
  } owner_e;

  typedef enum logic [1:0] {
    RT_NONE,
    RT_CORE,
    RT_DMA
  } rtag_e;

  owner_e        owner_q, owner_d;
  rtag_e         rtag_q, rtag_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          cg, dg;
  logic          core_gnt;

  always_comb begin
    owner_d  = owner_q;
    starve_d = starve_q;
    burst_d  = burst_q;
    cg       = 1'b0;
    dg       = 1'b0;
    if (owner_q == CORE_OWN) begin
      unique case (1'b1)
        (core_req & dma_req & (starve_q == SLIM)): begin
          dg       = 1'b1;
          owner_d  = DMA_OWN;
          burst_d  = BW'(1);
          starve_d = '0;
        end
        (core_req & dma_req & (starve_q != SLIM)): begin
          cg       = 1'b1;
          starve_d = starve_q + SW'(1);
        end
        (core_req & ~dma_req): begin
          cg       = 1'b1;
          starve_d = '0;
        end
        (~core_req & dma_req): begin
          dg       = 1'b1;
          owner_d  = DMA_OWN;
          burst_d  = BW'(1);
          starve_d = '0;
        end
        default: starve_d = '0;
      endcase
    end else begin
      unique case (1'b1)
        (dma_req & (burst_q < BMAX)): begin
          dg      = 1'b1;
          burst_d = burst_q + BW'(1);
        end
        (dma_req & (burst_q >= BMAX) & core_req): begin
          cg       = 1'b1;
          owner_d  = CORE_OWN;
          starve_d = SW'(1);
          burst_d  = '0;
        end
        (dma_req & (burst_q >= BMAX) & ~core_req): begin
          dg = 1'b1;
        end
        default: begin
          cg       = core_req;
          owner_d  = CORE_OWN;
          burst_d  = '0;
          starve_d = '0;
        end
      endcase
    end
  end

  // Reset overrides every grant so nothing reaches memory mid-reset.
  assign core_gnt   = cg & ~reset;
  assign dma_gnt    = dg & ~reset;
  assign core_stall = core_req & ~core_gnt & ~reset;

  always_comb begin
    mem_cs    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    rtag_d    = RT_NONE;
    unique case (1'b1)
      core_gnt: begin
        mem_cs    = 1'b1;
        mem_wr    = core_wr;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_mask  = core_mask;
        rtag_d    = core_wr ? RT_NONE : RT_CORE;
      end
      dma_gnt: begin
        mem_cs    = 1'b1;
        mem_wr    = dma_wr;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_mask  = dma_mask;
        rtag_d    = dma_wr ? RT_NONE : RT_DMA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= CORE_OWN;
      rtag_q   <= RT_NONE;
      starve_q <= '0;
      burst_q  <= '0;
    end else begin
      owner_q  <= owner_d;
      rtag_q   <= rtag_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
    end
  end

  assign core_rvalid = (rtag_q == RT_CORE) & ~reset;
  assign dma_rvalid  = (rtag_q == RT_DMA) & ~reset;
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign dma_rdata   = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grants, fairness,
// read-return steering and reset behaviour.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_wr;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_mask;
  logic        core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        dma_req, dma_wr;
  logic [31:0] dma_addr, dma_wdata;
  logic [3:0]  dma_mask;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_cs, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  dmem_arbiter #(
    .AW(32), .DW(32),
    .STARVE_LIMIT(3), .DMA_MAX_HOLD(4)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_wr(core_wr),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_mask(core_mask), .core_stall(core_stall),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .dma_req(dma_req), .dma_wr(dma_wr),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_mask(dma_mask), .dma_gnt(dma_gnt),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_cs(mem_cs), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [13:0] pat;

  initial begin
    reset      = 1'b1;
    core_req   = 1'b1;
    core_wr    = 1'b0;
    core_addr  = 32'h0;
    core_wdata = 32'h0;
    core_mask  = 4'hF;
    dma_req    = 1'b1;
    dma_wr     = 1'b0;
    dma_addr   = 32'h0;
    dma_wdata  = 32'h0;
    dma_mask   = 4'hF;
    mem_rdata  = 32'h0;

    // grants suppressed while reset is high
    mid();
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_dgnt", 32'(dma_gnt), 32'd0);
    chk("rst_rv", 32'({core_rvalid, dma_rvalid}), 32'd0);
    tick();
    tick();
    reset    = 1'b0;
    core_req = 1'b0;
    dma_req  = 1'b0;

    // idle: memory outputs zero
    mid();
    chk("idle_cs", 32'(mem_cs), 32'd0);
    chk("idle_addr", mem_addr, 32'h0);
    tick();

    // core-only load from 0x40
    core_req  = 1'b1;
    core_addr = 32'h40;
    mid();
    chk("ld_cs", 32'(mem_cs), 32'd1);
    chk("ld_wr", 32'(mem_wr), 32'd0);
    chk("ld_addr", mem_addr, 32'h40);
    chk("ld_stall", 32'(core_stall), 32'd0);
    chk("ld_rv0", 32'(core_rvalid), 32'd0);
    tick();
    core_req  = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    mid();
    chk("ld_rv1", 32'(core_rvalid), 32'd1);
    chk("ld_rdata", core_rdata, 32'hDEADBEEF);
    chk("ld_drv", 32'(dma_rvalid), 32'd0);
    chk("ld_cs_idle", 32'(mem_cs), 32'd0);
    tick();
    mem_rdata = 32'h0;

    // DMA-only six writes, no gaps past DMA_MAX_HOLD
    dma_req = 1'b1;
    dma_wr  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dma_addr  = 32'h100 + 32'(i);
      dma_wdata = 32'hA000 + 32'(i);
      dma_mask  = 4'(i + 1);
      mid();
      chk("dw_gnt", 32'(dma_gnt), 32'd1);
      chk("dw_wr", 32'(mem_wr), 32'd1);
      chk("dw_addr", mem_addr, 32'h100 + 32'(i));
      chk("dw_wdata", mem_wdata, 32'hA000 + 32'(i));
      chk("dw_mask", 32'(mem_mask), 32'(i + 1));
      tick();
    end
    dma_req = 1'b0;
    mid();
    chk("dw_rv", 32'({core_rvalid, dma_rvalid}), 32'd0);
    tick();

    // both requesting: C C C D D D D C C C D D D D
    pat        = 14'b11110001111000;
    core_req   = 1'b1;
    core_wr    = 1'b1;
    core_addr  = 32'h300;
    core_wdata = 32'h5555;
    dma_req    = 1'b1;
    dma_wr     = 1'b1;
    dma_addr   = 32'h400;
    for (int i = 0; i < 14; i++) begin
      mid();
      chk("fair_dgnt", 32'(dma_gnt), 32'(pat[i]));
      chk("fair_stall", 32'(core_stall), 32'(pat[i]));
      chk("fair_addr", mem_addr,
          pat[i] ? 32'h400 : 32'h300);
      tick();
    end
    core_req = 1'b0;
    dma_req  = 1'b0;
    tick();

    // alternating reads core 0x10 then DMA 0x20
    core_req  = 1'b1;
    core_wr   = 1'b0;
    core_addr = 32'h10;
    mid();
    chk("alt_caddr", mem_addr, 32'h10);
    chk("alt_cstall", 32'(core_stall), 32'd0);
    tick();
    core_req  = 1'b0;
    dma_req   = 1'b1;
    dma_wr    = 1'b0;
    dma_addr  = 32'h20;
    mem_rdata = 32'h11110010;
    mid();
    chk("alt_dgnt", 32'(dma_gnt), 32'd1);
    chk("alt_daddr", mem_addr, 32'h20);
    chk("alt_crv", 32'(core_rvalid), 32'd1);
    chk("alt_crd", core_rdata, 32'h11110010);
    chk("alt_drv0", 32'(dma_rvalid), 32'd0);
    chk("alt_drd0", dma_rdata, 32'h0);
    tick();
    dma_req   = 1'b0;
    mem_rdata = 32'h22220020;
    mid();
    chk("alt_drv1", 32'(dma_rvalid), 32'd1);
    chk("alt_drd1", dma_rdata, 32'h22220020);
    chk("alt_crv1", 32'(core_rvalid), 32'd0);
    chk("alt_crd1", core_rdata, 32'h0);
    tick();
    mem_rdata = 32'h0;

    // DMA drops after two beats while core waits
    dma_req  = 1'b1;
    dma_wr   = 1'b1;
    dma_addr = 32'h500;
    tick();
    core_req  = 1'b1;
    core_wr   = 1'b1;
    core_addr = 32'h600;
    mid();
    chk("drop_b2", 32'(dma_gnt), 32'd1);
    chk("drop_b2st", 32'(core_stall), 32'd1);
    tick();
    dma_req = 1'b0;
    mid();
    chk("drop_cs", 32'(mem_cs), 32'd1);
    chk("drop_addr", mem_addr, 32'h600);
    chk("drop_stall", 32'(core_stall), 32'd0);
    chk("drop_dgnt", 32'(dma_gnt), 32'd0);
    tick();
    dma_req = 1'b1;
    mid();
    chk("drop_own", 32'(dma_gnt), 32'd0);
    chk("drop_own_st", 32'(core_stall), 32'd0);
    tick();
    core_req = 1'b0;
    dma_req  = 1'b0;
    tick();

    // reset during the second DMA read beat
    dma_req  = 1'b1;
    dma_wr   = 1'b0;
    dma_addr = 32'h50;
    tick();
    mem_rdata = 32'hAAAA0050;
    mid();
    chk("rb_gnt2", 32'(dma_gnt), 32'd1);
    chk("rb_rv1", 32'(dma_rvalid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rb_rgnt", 32'(dma_gnt), 32'd0);
    chk("rb_rcs", 32'(mem_cs), 32'd0);
    chk("rb_rrv", 32'(dma_rvalid), 32'd0);
    tick();
    reset     = 1'b0;
    core_req  = 1'b1;
    core_wr   = 1'b0;
    core_addr = 32'h70;
    mem_rdata = 32'hBBBB0000;
    mid();
    chk("rb_drv", 32'(dma_rvalid), 32'd0);
    chk("rb_dgnt", 32'(dma_gnt), 32'd0);
    chk("rb_stall", 32'(core_stall), 32'd0);
    chk("rb_addr", mem_addr, 32'h70);
    tick();
    core_req  = 1'b0;
    dma_req   = 1'b0;
    mem_rdata = 32'hC0FFEE00;
    mid();
    chk("rb_crv", 32'(core_rvalid), 32'd1);
    chk("rb_crd", core_rdata, 32'hC0FFEE00);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
